// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM encoding, counter width default, feedback taps and step function
package lfsr_pkg;
    localparam int CNT_W_DEF = 4;
    // feedback bit is the XOR of the tapped bits s[1] and s[0]
    localparam logic [3:0] TAPS = 4'b0011;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;
    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {^(s & TAPS), s[3:1]};
    endfunction
endpackage

// File: rtl/lfsr_sequencer_if.sv
// lfsr_sequencer_if: run request (start/seed/steps/stop) and completion status (busy/done/flags/result/count)
interface lfsr_sequencer_if import lfsr_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
    logic start, stop, busy, done, err, wrapped, aborted;
    logic [3:0] seed, result;
    logic [CNT_W-1:0] steps, count;
    modport master (output start, seed, steps, stop, input busy, done, err, wrapped, aborted, result, count);
    modport slave (input start, seed, steps, stop, output busy, done, err, wrapped, aborted, result, count);
endinterface

// File: rtl/lfsr_core4.sv
// lfsr_core4: 4-bit LFSR register
//   clk, reset (async active-low), load: take din, otherwise step; q: current state
module lfsr_core4 import lfsr_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] din,
    output logic [3:0] q
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= '0;
        else q <= load ? din : lfsr_next(q);
endmodule

// File: rtl/lfsr_sequencer.sv
// lfsr_sequencer: runs the LFSR from a seed for N steps or until it wraps, reporting result and count
//   clk, reset (async active-low); bus: slave side of lfsr_sequencer_if
module lfsr_sequencer import lfsr_pkg::*; #(parameter int CNT_W = CNT_W_DEF) (
    input logic clk,
    input logic reset,
    lfsr_sequencer_if.slave bus
);
    state_t state;
    logic [3:0] seed_r, q, nxt;
    logic [CNT_W-1:0] steps_r, cnt, cnt_inc;
    logic hit_steps, hit_seed;
    assign nxt = lfsr_next(q);
    assign cnt_inc = cnt + CNT_W'(1);
    assign hit_steps = (steps_r != '0) && (cnt_inc == steps_r);
    assign hit_seed = nxt == seed_r;
    lfsr_core4 u_core (.clk(clk), .reset(reset), .load(state == LOAD), .din(seed_r), .q(q));
    // the core free-runs outside LOAD; result is sampled here, so a stop edge reports the unadvanced q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            seed_r <= '0;
            steps_r <= '0;
            cnt <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err <= 1'b0;
            bus.wrapped <= 1'b0;
            bus.aborted <= 1'b0;
            bus.result <= '0;
            bus.count <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.err <= 1'b0;
            bus.wrapped <= 1'b0;
            bus.aborted <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    if (bus.seed == 4'b0000) begin
                        bus.done <= 1'b1;
                        bus.err <= 1'b1;
                        bus.result <= '0;
                        bus.count <= '0;
                    end else begin
                        seed_r <= bus.seed;
                        steps_r <= bus.steps;
                        cnt <= '0;
                        bus.busy <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: state <= RUN;
                RUN: if (bus.stop) begin
                    state <= FIN;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    bus.aborted <= 1'b1;
                    bus.result <= q;
                    bus.count <= cnt;
                end else begin
                    cnt <= cnt_inc;
                    if (hit_steps || hit_seed) begin
                        state <= FIN;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.wrapped <= hit_seed;
                        bus.result <= nxt;
                        bus.count <= cnt_inc;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_sequencer.sv
// tb_lfsr_sequencer: directed scoreboard bench for lfsr_sequencer
module tb_lfsr_sequencer;
    typedef struct {
        logic [3:0] result;
        logic [3:0] count;
        logic err;
        logic wrapped;
        logic aborted;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [3:0] seq [15] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011, 4'b0101,
                             4'b1010, 4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

    lfsr_sequencer_if #(.CNT_W(4)) bus ();
    lfsr_sequencer #(.CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [3:0] step(input logic [3:0] s);
        return {s[0] ^ s[1], s[3], s[2], s[1]};
    endfunction

    function automatic exp_t mk(input logic [3:0] r, input logic [3:0] c, input logic er, input logic wr,
                                input logic ab, input int lat);
        exp_t e;
        e.result = r;
        e.count = c;
        e.err = er;
        e.wrapped = wr;
        e.aborted = ab;
        e.lat = lat;
        return e;
    endfunction

    // reference behaviour: stop_cyc counts cycles after start (1 = LOAD, 2.. = RUN)
    function automatic exp_t model(input logic [3:0] sd, input logic [3:0] st, input int stop_cyc);
        exp_t e;
        logic [3:0] s;
        int n;
        int k;
        e = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0);
        if (sd == 4'b0000) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        s = sd;
        n = 0;
        for (k = 1; k <= 40; k++) begin
            if (stop_cyc == k + 1) begin
                e.aborted = 1'b1;
                break;
            end
            s = step(s);
            n++;
            if (s == sd) begin
                e.wrapped = 1'b1;
                break;
            end
            if (st != 4'd0 && n == int'(st)) break;
        end
        e.result = s;
        e.count = n[3:0];
        e.lat = k + 2;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // starts a run at a negedge, pulses a start with seed 0 in cycle 2 (must be ignored), applies stop in stop_cyc
    task automatic run(input string name, input logic [3:0] sd, input logic [3:0] st, input int stop_cyc, input exp_t e);
        exp_t got;
        int cyc;
        logic seen;
        logic busy_seen;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.seed = sd;
        bus.steps = st;
        bus.stop = 1'b0;
        cyc = 0;
        seen = 1'b0;
        busy_seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            busy_seen |= bus.busy;
            if (bus.done) begin
                seen = 1'b1;
                got = sb.pop_front();
                chk($sformatf("%s result", name), 32'(bus.result), 32'(got.result));
                chk($sformatf("%s count", name), 32'(bus.count), 32'(got.count));
                chk($sformatf("%s flags", name), 32'({bus.err, bus.wrapped, bus.aborted}),
                    32'({got.err, got.wrapped, got.aborted}));
                chk($sformatf("%s latency", name), 32'(cyc), 32'(got.lat));
            end else begin
                bus.start = (cyc == 2);
                bus.seed = (cyc == 2) ? 4'b0000 : sd;
                bus.stop = (cyc == stop_cyc);
            end
        end
        bus.start = 1'b0;
        bus.stop = 1'b0;
        chk($sformatf("%s done seen", name), 32'(seen), 32'(1));
        if (!seen) void'(sb.pop_front());
        chk($sformatf("%s busy seen", name), 32'(busy_seen), 32'(sd != 4'b0000));
        @(negedge clk);
        chk($sformatf("%s pulse end", name), 32'({bus.done, bus.err, bus.wrapped, bus.aborted}), 32'(0));
        chk($sformatf("%s result held", name), 32'(bus.result), 32'(e.result));
    endtask

    initial begin
        int done_seen;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.seed = 4'b0000;
        bus.steps = 4'd0;
        #2 reset = 1'b0;
        #3;
        chk("reset outputs", 32'({bus.busy, bus.done, bus.err, bus.wrapped, bus.aborted, bus.result, bus.count}), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run("seed8_steps3", 4'b1000, 4'd3, 0, mk(4'b1001, 4'd3, 1'b0, 1'b0, 1'b0, 5));
        run("seed0", 4'b0000, 4'd5, 0, mk(4'b0000, 4'd0, 1'b1, 1'b0, 1'b0, 1));
        run("seed8_wrap", 4'b1000, 4'd0, 0, mk(4'b1000, 4'd15, 1'b0, 1'b1, 1'b0, 17));
        for (int n = 1; n < 15; n++)
            run($sformatf("seq%0d", n), 4'b1000, 4'(n), 0, mk(seq[n], 4'(n), 1'b0, 1'b0, 1'b0, n + 2));
        run("seed1_coincide", 4'b0001, 4'd15, 0, mk(4'b0001, 4'd15, 1'b0, 1'b1, 1'b0, 17));
        run("seed8_stop", 4'b1000, 4'd10, 4, mk(4'b0010, 4'd2, 1'b0, 1'b0, 1'b1, 5));
        run("stop_in_load", 4'b0101, 4'd4, 1, model(4'b0101, 4'd4, 1));
        run("seedc_stop", 4'b1100, 4'd0, 6, model(4'b1100, 4'd0, 6));
        run("seed3_steps7", 4'b0011, 4'd7, 0, model(4'b0011, 4'd7, 0));

        bus.start = 1'b1;
        bus.seed = 4'b1000;
        bus.steps = 4'd10;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrun busy", 32'(bus.busy), 32'(1));
        #2 reset = 1'b0;
        #1;
        chk("midrun reset outputs", 32'({bus.busy, bus.done, bus.err, bus.wrapped, bus.aborted, bus.result, bus.count}), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        chk("no stale done", 32'(done_seen), 32'(0));
        run("after_reset", 4'b1111, 4'd1, 0, mk(4'b0111, 4'd1, 1'b0, 1'b0, 1'b0, 3));

        chk("scoreboard empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
